// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_RESET = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is read straight from storage registers.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; flush empties the queue without touching data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head and status flags.
  always_comb begin
    head_data = mem[rd_ptr];
    empty     = (count == '0);
    full      = (count == FULL_CNT);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word fetches, buffers
// responses with their PCs and hands one instruction per cycle to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_t state;
  logic         fault_q;
  logic [31:0]  fetch_pc;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   occupancy;
  logic [63:0]  buf_head;
  logic [31:0]  rsp_pc;
  logic         buf_empty, buf_full, pcq_empty, pcq_full;
  logic         target_ok, credit_ok, req_fire, rsp_keep, buf_pop;

  // Handshake gating and credit accounting.
  // A pop in the same cycle frees its slot immediately; this is what sustains
  // one fetch per cycle at FIFO_DEPTH=2 while still never overflowing the buffer.
  always_comb begin
    target_ok      = is_word_aligned(redirect_target);
    instr_valid    = (state == FETCH_RUN) && !buf_empty && !redirect;
    buf_pop        = instr_valid && instr_ready;
    occupancy      = {1'b0, outstanding} + {1'b0, buf_count} - {{CNT_W{1'b0}}, buf_pop};
    credit_ok      = (occupancy < DEPTH_X);
    imem_req_valid = (state == FETCH_RUN) && credit_ok && !redirect;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect;
  end

  assign imem_addr   = fetch_pc;
  assign instr       = buf_head[31:0];
  assign instr_pc    = buf_head[63:32];
  assign fetch_fault = fault_q;

  // Fetch state machine with registered fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH_RESET;
      fault_q <= 1'b0;
    end else begin
      case (state)
        FETCH_RESET: state <= FETCH_RUN;
        FETCH_RUN: begin
          if (redirect && !target_ok) begin
            state   <= FETCH_FAULT;
            fault_q <= 1'b1;
          end
        end
        FETCH_FAULT: begin
          if (redirect && target_ok) begin
            state   <= FETCH_RUN;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state   <= FETCH_RUN;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  // Program counter: aligned redirects win over sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect && target_ok) begin
      fetch_pc <= redirect_target;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + PC_INC;
    end
  end

  // Stale-response counter: everything still in flight after a redirect is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // PCs of in-flight requests; its occupancy is the outstanding count.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire && !pcq_full),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid && !pcq_empty),
    .head_data (rsp_pc),
    .count     (outstanding),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  // Instruction buffer of {pc, instr} entries feeding decode.
  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (rsp_keep && (!buf_full || buf_pop)),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus random bench for instr_fetch_unit with an in-order memory model
// and a scoreboard of expected decode-side PCs.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // memory model state
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;
  bit          rand_mode = 0;
  int unsigned acc_cnt = 0;
  logic [31:0] exp_req_addr = 32'h0;
  logic [31:0] last_acc = 32'h0;
  bit          wrap_seen = 0;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = 32'h0;
  bit          exp_en = 1;
  int unsigned consumed = 0;
  logic [31:0] last_pc = 32'h0;
  bit          hold_pending = 0;
  logic [31:0] hold_pc, hold_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect        = 1'b1;
    redirect_target = t;
    exp_q.delete();
    if (t[1:0] == 2'b00) begin
      exp_en       = 1;
      gen_pc       = t;
      exp_req_addr = t;
      exp_q.push_back(t);
      gen_pc       = t + 32'd4;
    end else begin
      exp_en = 0;
    end
  endtask

  task automatic wait_consume(input string tag, input int unsigned c0, input logic [31:0] exp);
    for (int k = 0; k < 30 && consumed == c0; k++) begin
      tick();
      mid();
    end
    chk(tag, last_pc, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // memory: accepts per ready, answers in order after its latency
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
        cyc = 0;
      end else begin
        cyc++;
      end
      #1;
      if (rst_n && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr.pop_front());
        pend_due.delete(0);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      imem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        if (imem_addr == 32'h0 && last_acc == 32'hFFFF_FFFC) wrap_seen = 1;
        last_acc = imem_addr;
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + (rand_mode ? $urandom_range(1, 4) : mem_lat));
        acc_cnt++;
        chk("outstanding_le_depth", (pend_addr.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
      end
    end
  end

  // decode-side monitor: pops the scoreboard on every consumed instruction
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pending && !redirect) begin
          chk("hold_valid", {31'b0, instr_valid}, 32'd1);
          chk("hold_pc", instr_pc, hold_pc);
          chk("hold_instr", instr, hold_instr);
        end
        if (instr_valid && instr_ready) begin
          if (exp_en && exp_q.size() == 0) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_instr_valid", {31'b0, instr_valid}, 32'd0);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e);
            chk("instr_word", instr, mem_word(e));
          end
          last_pc = instr_pc;
          consumed++;
        end
        hold_pending = instr_valid && !instr_ready;
        hold_pc      = instr_pc;
        hold_instr   = instr;
      end else begin
        hold_pending = 0;
      end
    end
  end

  initial begin
    int unsigned v;
    int unsigned a0;
    int unsigned c0;
    logic [31:0] held;

    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    instr_ready     = 1'b1;
    exp_en          = 1;
    gen_pc          = 32'h0;
    exp_req_addr    = 32'h0;

    // reset values
    repeat (2) tick();
    mid();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // release: first request the cycle after RESET->RUN, data two cycles later
    tick();
    rst_n = 1'b1;
    tick();
    mid();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_addr, 32'h0);
    chk("first_instr_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    mid();
    chk("second_req_addr", imem_addr, 32'h4);
    chk("second_instr_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    mid();
    chk("third_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("third_instr_pc", instr_pc, 32'h0);
    v = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      mid();
      if (instr_valid) v++;
    end
    chk("throughput_16", v, 32'd16);

    // decode stall: credits stop fetch, head holds
    tick();
    instr_ready = 1'b0;
    a0 = acc_cnt;
    mid();
    held = instr_pc;
    for (int k = 0; k < 4; k++) begin
      tick();
      mid();
    end
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_head_pc", instr_pc, held);
    chk("stall_accepts_le_depth", (acc_cnt - a0 <= 2) ? 32'd1 : 32'd0, 32'd1);
    tick();
    instr_ready = 1'b1;
    repeat (10) begin
      tick();
      mid();
    end

    // redirect with two requests in flight on a slower memory
    mem_lat = 3;
    tick();
    for (int k = 0; k < 40 && pend_addr.size() != 2; k++) tick();
    chk("two_outstanding", 32'(pend_addr.size()), 32'd2);
    c0 = consumed;
    do_redirect(32'h0000_0100);
    mid();
    chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("redir_instr_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    mid();
    wait_consume("redir_first_pc", c0, 32'h0000_0100);
    mem_lat = 1;
    repeat (8) begin
      tick();
      mid();
    end

    // misaligned target faults, aligned target recovers
    tick();
    do_redirect(32'h0000_0102);
    mid();
    chk("fault_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    mid();
    chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      mid();
      chk("fault_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("fault_no_instr", {31'b0, instr_valid}, 32'd0);
    end
    tick();
    c0 = consumed;
    do_redirect(32'h0000_0200);
    mid();
    chk("recover_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    mid();
    chk("recover_fault_clear", {31'b0, fetch_fault}, 32'd0);
    chk("recover_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("recover_req_addr", imem_addr, 32'h0000_0200);
    wait_consume("recover_first_pc", c0, 32'h0000_0200);

    // address wrap at the top of the space
    tick();
    do_redirect(32'hFFFF_FFF8);
    mid();
    tick();
    redirect = 1'b0;
    mid();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    mid();
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    mid();
    chk("wrap_addr2", imem_addr, 32'h0000_0000);
    repeat (8) begin
      tick();
      mid();
    end
    chk("wrap_seen", {31'b0, wrap_seen}, 32'd1);

    // random memory ready/latency and decode back-pressure
    c0 = consumed;
    rand_mode = 1;
    for (int k = 0; k < 10000; k++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      mid();
    end
    rand_mode   = 0;
    tick();
    instr_ready = 1'b1;
    repeat (30) begin
      tick();
      mid();
    end
    chk("random_progress", (consumed - c0 > 1000) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
